// File: rtl/vector_element_sequencer.sv
// vector_element_sequencer: issues one vector instruction NUM_LANES elements per beat with masking and register-group offsets
module vector_element_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int VLEN = 128,
    parameter int VLW = $clog2(VLEN) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic                 ready,
    input  logic [VLW-1:0]       vl,
    input  logic [1:0]           sew,
    input  logic                 vd_widen,
    input  logic                 vs2_widen,
    input  logic                 vm,
    input  logic [4:0]           vs1,
    input  logic [4:0]           vs2,
    input  logic [4:0]           vd,
    input  logic [NUM_LANES-1:0] mask_bits,
    input  logic                 stall,
    output logic                 beat_valid,
    output logic [VLW-1:0]       elem_idx,
    output logic [NUM_LANES-1:0] lane_valid,
    output logic [4:0]           vs1_reg,
    output logic [4:0]           vs2_reg,
    output logic [4:0]           vd_reg,
    output logic                 done,
    output logic                 illegal
);
    localparam int LV = $clog2(VLEN);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_n;
    logic [VLW-1:0] vl_q, elem_q, elem_n;
    logic [1:0] sew_q, k_vs2, k_vd;
    logic vdw_q, vs2w_q, vm_q, ill_q, zero_q, accept, bad, last, consume;
    logic [4:0] vs1_q, vs2_q, vd_q;
    // EEW code k means 8<<k bits, so VLEN>>(3+k) elements fit in one register
    function automatic logic [4:0] offs(input logic [VLW-1:0] e, input logic [1:0] k);
        logic [VLW-1:0] t;
        t = e >> (LV - 3 - int'(k));
        return t[4:0];
    endfunction
    assign ready = state == IDLE;
    assign beat_valid = state == ISSUE;
    assign accept = ready & start & ~ill_q & ~zero_q;
    assign bad = (sew == 2'd3) | ((sew == 2'd2) & (vd_widen | vs2_widen));
    assign last = ({1'b0, elem_q} + (VLW+1)'(NUM_LANES)) >= {1'b0, vl_q};
    assign consume = beat_valid & ~stall;
    assign k_vs2 = sew_q + {1'b0, vs2w_q};
    assign k_vd = sew_q + {1'b0, vdw_q};
    always_comb begin
        state_n = state;
        elem_n = elem_q;
        if (accept && !bad && vl != '0) begin
            state_n = ISSUE;
            elem_n = '0;
        end
        if (consume) begin
            state_n = last ? IDLE : ISSUE;
            elem_n = last ? elem_q : elem_q + VLW'(NUM_LANES);
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            elem_q <= '0;
            ill_q <= 1'b0;
            zero_q <= 1'b0;
            vl_q <= '0;
            sew_q <= '0;
            vdw_q <= 1'b0;
            vs2w_q <= 1'b0;
            vm_q <= 1'b0;
            vs1_q <= '0;
            vs2_q <= '0;
            vd_q <= '0;
        end else begin
            state <= state_n;
            elem_q <= elem_n;
            ill_q <= accept & bad;
            zero_q <= accept & ~bad & (vl == '0);
            if (accept) begin
                vl_q <= vl;
                sew_q <= sew;
                vdw_q <= vd_widen;
                vs2w_q <= vs2_widen;
                vm_q <= vm;
                vs1_q <= vs1;
                vs2_q <= vs2;
                vd_q <= vd;
            end
        end
    end
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_valid[i] = beat_valid & (({1'b0, elem_q} + (VLW+1)'(i)) < {1'b0, vl_q}) & (vm_q | mask_bits[i]);
    end
    assign elem_idx = beat_valid ? elem_q : '0;
    assign vs1_reg = beat_valid ? vs1_q + offs(elem_q, sew_q) : '0;
    assign vs2_reg = beat_valid ? vs2_q + offs(elem_q, k_vs2) : '0;
    assign vd_reg = beat_valid ? vd_q + offs(elem_q, k_vd) : '0;
    assign done = (consume & last) | zero_q;
    assign illegal = ill_q;
endmodule

// File: tb/tb_vector_element_sequencer.sv
// tb_vector_element_sequencer: randomized self-checking bench against an arithmetic model of beat issue
module tb_vector_element_sequencer;
    localparam int NL = 2;
    localparam int VL = 128;
    localparam int W = $clog2(VL) + 1;
    localparam int OW = 4 + W + NL + 15;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0, vd_widen = 1'b0, vs2_widen = 1'b0, vm = 1'b1, stall = 1'b0;
    logic [W-1:0] vl = '0;
    logic [1:0] sew = '0;
    logic [4:0] vs1 = '0, vs2 = '0, vd = '0;
    logic [NL-1:0] mask_bits = '0;
    logic ready, beat_valid, done, illegal;
    logic [W-1:0] elem_idx;
    logic [NL-1:0] lane_valid;
    logic [4:0] vs1_reg, vs2_reg, vd_reg;
    int n_cmp = 0, n_bad = 0;
    always #5 CLK = ~CLK;
    vector_element_sequencer #(.NUM_LANES(NL), .VLEN(VL)) dut (
        .CLK(CLK), .RST(RST), .start(start), .ready(ready), .vl(vl), .sew(sew),
        .vd_widen(vd_widen), .vs2_widen(vs2_widen), .vm(vm), .vs1(vs1), .vs2(vs2), .vd(vd),
        .mask_bits(mask_bits), .stall(stall), .beat_valid(beat_valid), .elem_idx(elem_idx),
        .lane_valid(lane_valid), .vs1_reg(vs1_reg), .vs2_reg(vs2_reg), .vd_reg(vd_reg),
        .done(done), .illegal(illegal)
    );
    function automatic logic [OW-1:0] obs();
        return {beat_valid, ready, done, illegal, elem_idx, lane_valid, vs1_reg, vs2_reg, vd_reg};
    endfunction
    localparam logic [OW-1:0] IDLE_EXP = {1'b0, 1'b1, 2'b00, (OW-4)'(0)};
    task automatic run_instr(input int vl_i, input int sew_i, input bit vdw_i, input bit vs2w_i, input bit vm_i,
                             input int vs1_i, input int vs2_i, input int vd_i, input int pct,
                             input logic [31:0] spat, input bit mfix, input logic [NL-1:0] mval, output int cyc);
        int elem;
        bit bad;
        logic [NL-1:0] lv;
        logic [OW-1:0] e;
        @(posedge CLK); #1;
        start = 1'b1; vl = W'(vl_i); sew = 2'(sew_i); vd_widen = vdw_i; vs2_widen = vs2w_i; vm = vm_i;
        vs1 = 5'(vs1_i); vs2 = 5'(vs2_i); vd = 5'(vd_i); stall = 1'b0;
        #1;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_before_accept got=%b want=1", ready); end
        n_cmp++;
        @(posedge CLK); #1;
        start = 1'b0; vl = W'($urandom); sew = 2'($urandom); vs1 = 5'($urandom); vs2 = 5'($urandom); vd = 5'($urandom);
        vd_widen = 1'($urandom); vs2_widen = 1'($urandom); vm = 1'($urandom);
        bad = (sew_i == 3) || (sew_i == 2 && (vdw_i || vs2w_i));
        cyc = 0;
        if (bad || vl_i == 0) begin
            mask_bits = NL'($urandom);
            #1;
            e = {1'b0, 1'b1, !bad, bad, (OW-4)'(0)};
            if (obs() !== e) begin n_bad++; $display("FAIL pulse got=%h want=%h", obs(), e); end
            n_cmp++;
            start = 1'b1; vl = W'(2); sew = 2'd0; vd_widen = 1'b0; vs2_widen = 1'b0;
            @(posedge CLK); #1;
            start = 1'b0;
            #1;
            if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL start_in_pulse_ignored got=%h want=%h", obs(), IDLE_EXP); end
            n_cmp++;
            return;
        end
        elem = 0;
        while (elem < vl_i && cyc < 4000) begin
            stall = (cyc < 32 && spat[cyc]) || ($urandom_range(0, 99) < pct);
            mask_bits = mfix ? mval : NL'($urandom);
            start = 1'($urandom);
            #1;
            for (int i = 0; i < NL; i++) lv[i] = (elem + i < vl_i) && (vm_i || mask_bits[i]);
            e = {1'b1, 1'b0, !stall && (elem + NL >= vl_i), 1'b0, W'(elem), lv,
                 5'((vs1_i + elem * (8 << sew_i) / VL) % 32),
                 5'((vs2_i + elem * (8 << (sew_i + int'(vs2w_i))) / VL) % 32),
                 5'((vd_i + elem * (8 << (sew_i + int'(vdw_i))) / VL) % 32)};
            if (obs() !== e) begin n_bad++; $display("FAIL beat elem=%0d got=%h want=%h", elem, obs(), e); end
            n_cmp++;
            @(posedge CLK); #1;
            if (!stall) elem += NL;
            cyc++;
        end
        if (cyc >= 4000) begin n_bad++; $display("FAIL issue_timeout cycles=%0d want<4000", cyc); end
        stall = 1'b0; start = 1'b0;
        #1;
        if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL idle_after_done got=%h want=%h", obs(), IDLE_EXP); end
        n_cmp++;
    endtask
    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL reset_state got=%h want=%h", obs(), IDLE_EXP); end
        n_cmp++;
        RST = 1'b0;
        @(posedge CLK); #1;
        if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL after_reset got=%h want=%h", obs(), IDLE_EXP); end
        n_cmp++;
    endtask
    task automatic test_basic();
        int c;
        run_instr(5, 2, 0, 0, 1, 3, 6, 8, 0, 0, 0, '0, c);
        if (c !== 3) begin n_bad++; $display("FAIL basic_beats got=%0d want=3", c); end
        n_cmp++;
    endtask
    task automatic test_stall();
        int c;
        run_instr(5, 2, 0, 0, 1, 3, 6, 8, 0, 32'b1110, 0, '0, c);
        if (c !== 6) begin n_bad++; $display("FAIL stall_cycles got=%0d want=6", c); end
        n_cmp++;
    endtask
    task automatic test_widen();
        int c;
        run_instr(16, 0, 1, 0, 1, 1, 7, 4, 0, 0, 0, '0, c);
        run_instr(16, 1, 0, 1, 1, 30, 31, 2, 20, 0, 0, '0, c);
    endtask
    task automatic test_mask();
        int c;
        run_instr(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, c);
        run_instr(9, 1, 0, 0, 0, 5, 5, 5, 40, 0, 0, '0, c);
    endtask
    task automatic test_illegal_zero();
        int c;
        run_instr(8, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, '0, c);
        run_instr(8, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, '0, c);
        run_instr(8, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0, c);
        run_instr(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0, c);
    endtask
    task automatic test_reset_mid();
        int c;
        @(posedge CLK); #1;
        start = 1'b1; vl = W'(64); sew = 2'd0; vd_widen = 1'b0; vs2_widen = 1'b0; vm = 1'b1; stall = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        if (beat_valid !== 1'b1) begin n_bad++; $display("FAIL mid_issue_active got=%b want=1", beat_valid); end
        n_cmp++;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL reset_abort got=%h want=%h", obs(), IDLE_EXP); end
        n_cmp++;
        @(posedge CLK); #1;
        if (obs() !== IDLE_EXP) begin n_bad++; $display("FAIL reset_abort_no_done got=%h want=%h", obs(), IDLE_EXP); end
        n_cmp++;
        run_instr(7, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0, '0, c);
    endtask
    task automatic test_random();
        int c, s;
        for (int n = 0; n < 25; n++) begin
            s = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
            run_instr($urandom_range(0, VL), s, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      30, 0, 0, '0, c);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_widen();
        test_mask();
        test_illegal_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
